display_reg_bank: RTL and testbench

- Parametrised telemetry register bank for the dashboard display. It replaces the fixed 6-register decoder.
- Holds NUM_REGS registers of DATA_W bits, each written by address from the CAN/UART front end.
- Adds registered readback, per-register valid flags, staleness timeout detection and address-error reporting.
- Downstream display logic reads all registers in parallel from a flat bus and blanks or flags fields whose stale bit is set.

---
 rtl/display_reg_bank.sv | 157 +++++++++++++++
 tb/tb_display_reg_bank.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_reg_bank.sv
// display_reg_bank: telemetry register bank with readback, valid/stale flags
// Define DISPLAY_REG_SHADOW_EN to stage writes in shadow regs until commit.
module display_reg_bank #(
    parameter int NUM_REGS       = 8,
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 3,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int TMR_W          = 26
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       write,
    input  logic [DATA_W-1:0]          data_in,
`ifdef DISPLAY_REG_SHADOW_EN
    input  logic                       commit,
`endif
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        valid,
    output logic [NUM_REGS-1:0]        stale,
    output logic                       addr_err
);

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0]  NUM_L  = (ADDR_W+1)'(NUM_REGS);
    localparam logic [TMR_W-1:0] TMO    = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMO_M1 = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [DATA_W-1:0] regs      [NUM_REGS];
    logic [TMR_W-1:0]  cnt       [NUM_REGS];
    logic [DATA_W-1:0] load_data [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] load;
    logic [DATA_W-1:0]   rd_mux;
    logic                wr_ok;
    logic                rd_ok;

    assign wr_ok = ({1'b0, addr} < NUM_L);
    assign rd_ok = ({1'b0, rd_addr} < NUM_L);

    // Decode the write address into a one-hot hit vector
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = write && wr_ok && (addr == ADDR_W'(i));
        end
    end

    // Read-side mux over the live registers (pre-write values)
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_mux = regs[i];
            end
        end
    end

`ifdef DISPLAY_REG_SHADOW_EN
    logic [DATA_W-1:0]   shadow [NUM_REGS];
    logic [NUM_REGS-1:0] dirty;

    // Live load on commit: dirty entries plus any write landing this cycle
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            load[i]      = commit && (dirty[i] || wr_hit[i]);
            load_data[i] = wr_hit[i] ? data_in : shadow[i];
        end
    end

    // Shadow storage and dirty tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    shadow[i] <= data_in;
                end
                if (load[i]) begin
                    dirty[i] <= 1'b0;
                end else if (wr_hit[i]) begin
                    dirty[i] <= 1'b1;
                end
            end
        end
    end
`else
    // Writes go straight to the live registers
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            load[i]      = wr_hit[i];
            load_data[i] = data_in;
        end
    end
`endif

    // Live registers, valid flags and staleness timers; a load beats timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            stale <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (load[i]) begin
                    regs[i]  <= load_data[i];
                    valid[i] <= 1'b1;
                    stale[i] <= 1'b0;
                    cnt[i]   <= '0;
                end else if (valid[i] && (cnt[i] < TMO)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                    if (cnt[i] == TMO_M1) begin
                        stale[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Registered readback; out-of-range reads return zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_ok ? rd_mux : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

    // Single error pulse for any out-of-range access this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (write && !wr_ok) || (rd_en && !rd_ok);
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_display_reg_bank.sv
// tb_display_reg_bank: random + directed checks against a behavioural model
// Define DISPLAY_REG_SHADOW_EN to exercise the commit path.
module tb_display_reg_bank;

    localparam int N  = 6;
    localparam int W  = 8;
    localparam int AW = 3;
    localparam int T  = 10;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          write = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          commit = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [N*W-1:0] regs_flat;
    logic [N-1:0]  valid;
    logic [N-1:0]  stale;
    logic          addr_err;

    int checks = 0;
    int errors = 0;

    display_reg_bank #(
        .NUM_REGS(N), .DATA_W(W), .ADDR_W(AW),
        .TIMEOUT_CYCLES(T), .TMR_W(TW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .write(write),
        .data_in(data_in),
`ifdef DISPLAY_REG_SHADOW_EN
        .commit(commit),
`endif
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .regs_flat(regs_flat),
        .valid(valid),
        .stale(stale),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: values, write timestamps, pending shadow data
    logic [W-1:0] m_reg [N];
    logic [W-1:0] m_sh  [N];
    bit           m_dirty [N];
    bit           m_valid [N];
    int           m_last [N];
    int           cyc = 0;
    logic [W-1:0] m_rd_data;
    bit           m_rd_valid;
    bit           m_err;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    m_reg[i] = '0; m_sh[i] = '0;
                    m_dirty[i] = 0; m_valid[i] = 0; m_last[i] = 0;
                end
                m_rd_data = '0; m_rd_valid = 0; m_err = 0;
            end else begin
                cyc++;
                m_err = (write && addr >= N) || (rd_en && rd_addr >= N);
                if (rd_en) begin
                    m_rd_valid = 1;
                    if (rd_addr < N) m_rd_data = m_reg[rd_addr];
                    else m_rd_data = '0;
                end else begin
                    m_rd_valid = 0;
                end
`ifdef DISPLAY_REG_SHADOW_EN
                if (write && addr < N) begin
                    m_sh[addr] = data_in;
                    m_dirty[addr] = 1;
                end
                if (commit) begin
                    for (int i = 0; i < N; i++) begin
                        if (m_dirty[i]) begin
                            m_reg[i] = m_sh[i];
                            m_valid[i] = 1;
                            m_last[i] = cyc;
                            m_dirty[i] = 0;
                        end
                    end
                end
`else
                if (write && addr < N) begin
                    m_reg[addr] = data_in;
                    m_valid[addr] = 1;
                    m_last[addr] = cyc;
                end
`endif
            end
        end
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Per-cycle comparison of every output against the model
    initial begin
        logic [N*W-1:0] ef;
        logic [N-1:0]   ev;
        logic [N-1:0]   es;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < N; i++) begin
                    ef[i*W +: W] = m_reg[i];
                    ev[i] = m_valid[i];
                    es[i] = m_valid[i] && ((cyc - m_last[i]) >= T);
                end
                chk("regs_flat", 64'(regs_flat), 64'(ef));
                chk("valid", 64'(valid), 64'(ev));
                chk("stale", 64'(stale), 64'(es));
                chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
                chk("rd_data", 64'(rd_data), 64'(m_rd_data));
                chk("addr_err", 64'(addr_err), 64'(m_err));
            end
        end
    end

    task automatic tick(input bit w, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input bit r,
                        input logic [AW-1:0] ra);
        write = w; addr = a; data_in = d; rd_en = r; rd_addr = ra;
        @(posedge clk);
        #1;
        write = 0; rd_en = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, '0, 0, '0);
    endtask

    logic [N*W-1:0] snap;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regs", 64'(regs_flat), 64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_stale", 64'(stale), 64'h0);
        chk("rst_rdv", 64'(rd_valid), 64'h0);
        chk("rst_err", 64'(addr_err), 64'h0);
        rst_n = 1;
        idle(1);

`ifndef DISPLAY_REG_SHADOW_EN
        // Basic write
        tick(1, 3'd2, 8'h5A, 0, '0);
        chk("t1_reg2", 64'(regs_flat[23:16]), 64'h5A);
        chk("t1_valid", 64'(valid), 64'b000100);
        chk("t1_stale", 64'(stale), 64'h0);
        chk("t1_err", 64'(addr_err), 64'h0);

        // Staleness boundary on reg0
        tick(1, 3'd0, 8'h01, 0, '0);
        idle(9);
        chk("t2_k9", 64'(stale[0]), 64'h0);
        idle(1);
        chk("t2_k10", 64'(stale[0]), 64'h1);
        idle(1);
        tick(1, 3'd0, 8'h02, 0, '0);
        chk("t2_k12", 64'(stale[0]), 64'h0);

        // Out-of-range write and read
        snap = regs_flat;
        tick(1, 3'd7, 8'hFF, 0, '0);
        chk("t3_err", 64'(addr_err), 64'h1);
        chk("t3_regs", 64'(regs_flat), 64'(snap));
        idle(1);
        chk("t3_err_off", 64'(addr_err), 64'h0);
        tick(0, '0, '0, 1, 3'd6);
        chk("t3_rd", 64'(rd_data), 64'h0);
        chk("t3_rdv", 64'(rd_valid), 64'h1);
        chk("t3_err2", 64'(addr_err), 64'h1);

        // Read-during-write returns the old value
        tick(1, 3'd3, 8'h11, 0, '0);
        tick(1, 3'd3, 8'h22, 1, 3'd3);
        chk("t4_old", 64'(rd_data), 64'h11);
        chk("t4_rdv", 64'(rd_valid), 64'h1);
        tick(0, '0, '0, 1, 3'd3);
        chk("t4_new", 64'(rd_data), 64'h22);
`else
        // Shadow staging and commit
        tick(1, 3'd1, 8'h33, 0, '0);
        chk("t6_unch", 64'(regs_flat[15:8]), 64'h0);
        chk("t6_v0", 64'(valid), 64'h0);
        commit = 1;
        tick(1, 3'd4, 8'h44, 0, '0);
        commit = 0;
        chk("t6_reg1", 64'(regs_flat[15:8]), 64'h33);
        chk("t6_reg4", 64'(regs_flat[39:32]), 64'h44);
        chk("t6_valid", 64'(valid), 64'b010010);
        tick(0, '0, '0, 1, 3'd1);
        chk("t6_rd", 64'(rd_data), 64'h33);
`endif

        // Asynchronous reset mid-cycle
        commit = 1;
        tick(1, 3'd5, 8'hA5, 0, '0);
        tick(1, 3'd1, 8'h7E, 0, '0);
        tick(0, '0, '0, 1, 3'd5);
        commit = 0;
        chk("t5_pre", 64'(rd_data), 64'hA5);
        #2;
        rst_n = 0;
        #1;
        chk("t5_regs", 64'(regs_flat), 64'h0);
        chk("t5_valid", 64'(valid), 64'h0);
        chk("t5_stale", 64'(stale), 64'h0);
        chk("t5_rd", 64'(rd_data), 64'h0);
        chk("t5_rdv", 64'(rd_valid), 64'h0);
        chk("t5_err", 64'(addr_err), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(T + 2);
        chk("t5_nostale", 64'(stale), 64'h0);
        chk("t5_novalid", 64'(valid), 64'h0);

        // Randomised traffic; sparse writes let registers time out
        for (int n = 0; n < 600; n++) begin
            commit = ($urandom_range(0, 5) == 0);
            tick($urandom_range(0, 5) == 0, AW'($urandom_range(0, 7)),
                 W'($urandom), $urandom_range(0, 2) == 0,
                 AW'($urandom_range(0, 7)));
        end
        commit = 0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
